mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port byte-wide memory between two 16-bit requesters of the accumulator CPU:
//  port 0 = instruction fetch, port 1 = data (LD/ST/ADD/CMP operand).
//  Each word access is split into two byte beats, big-endian: high byte at addr, low byte at addr+1.
//  Sits between the CPU core and the memory array; fairness between ports is round-robin.
// PARAMETERS
//  AW     16  byte-address width for requesters and memory
//  CNT_W  16  width of per-port access counters (used only with MEM_ARB_STATS_EN)
// PORTS
//  clock        in   1      single clock; all state updates on its rising edge
//  reset        in   1      synchronous, active-high
//  req_i        in   2      per-port access request (bit0 fetch, bit1 data)
//  we_i         in   2      per-port write enable, qualified by req_i
//  addr0_i      in   AW     port 0 word byte-address
//  addr1_i      in   AW     port 1 word byte-address
//  wdata0_i     in   16     port 0 write word
//  wdata1_i     in   16     port 1 write word
//  gnt_o        out  2      one-hot owner of the memory, HI through RESP inclusive
//  done_o       out  2      one-cycle completion pulse to the owning port
//  rdata_o      out  16     read word; valid while done_o is set for a read
//  mem_en_o     out  1      memory beat enable
//  mem_we_o     out  1      memory beat write
//  mem_addr_o   out  AW     memory byte address
//  mem_wdata_o  out  8      memory write byte
//  mem_rdata_i  in   8      memory read byte; valid the cycle after a read beat (1-cycle latency)
// BEHAVIOUR
//  - Reset values: gnt_o=0, done_o=0, rdata_o=0, mem_en_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
//    State = IDLE, last_gnt = port 1, so port 0 wins the first tie.
//  - FSM: IDLE -> HI -> LO -> CAP -> RESP -> IDLE. All outputs are registered.
//  - IDLE: if any req_i bit is set, pick the winner and latch its we/addr/wdata.
//      One requester: that port wins. Both: the port != last_gnt wins.
//      Set gnt_o and last_gnt, then go to HI. Inputs are sampled only at this grant edge.
//  - HI: mem_en_o=1, mem_addr_o=addr, mem_we_o=we, mem_wdata_o=wdata[15:8].
//  - LO: mem_en_o=1, mem_addr_o=addr+1 (mod 2^AW; 0xFFFF wraps to 0x0000), mem_wdata_o=wdata[7:0].
//      Latch mem_rdata_i into the high byte.
//  - CAP: mem_en_o=0. Latch mem_rdata_i into the low byte.
//  - RESP: done_o[owner]=1 and rdata_o={hi,lo}, then return to IDLE. Requests are ignored in RESP.
//  - Writes use identical timing; rdata_o is unchanged on a write.
//  - Latency: req sampled in cycle N -> done_o in cycle N+4. Maximum 1 access per 5 cycles.
//  - Handshake: the requester drops req_i in the cycle it sees done_o.
//    Any req_i high while in IDLE is a new request.
//  - A losing requester holds req_i and is served next. Round-robin bounds its wait to one access.
//  - gnt_o and done_o are never set for both ports at once; done_o goes only to the latched owner.
//  - Reset mid-access returns to IDLE on the next edge. The access is dropped and no done_o is issued.
//    A write reset after HI may leave only the high byte written; this is accepted.
// CONFIGURATION
//  - MEM_ARB_STATS_EN defined: adds ports cnt0_o, cnt1_o (out, CNT_W), each counting that port's
//    done_o pulses. Reset value 0; counters saturate at all-ones and do not wrap.
//  - MEM_ARB_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  - Package mem_arb_pkg: FSM state enum (IDLE, HI, LO, CAP, RESP) and port index constants
//    PORT_FETCH=0, PORT_DATA=1.
//  - Sub-module rr_arb2: combinational 2-way round-robin pick from (req, last_gnt) giving a one-hot grant.
//    The FSM, last_gnt register and datapath latches stay in the top module.
// TESTING
//  - Single read: memory holds 0x12 at 0x0004 and 0x34 at 0x0005; port 0 reads 0x0004.
//    -> mem_addr_o is 0x0004 then 0x0005; done_o=01 four cycles after req; rdata_o=0x1234.
//  - Single write: port 1 writes 0xBEEF to 0x0010.
//    -> beats (0x0010,0xBE,we) then (0x0011,0xEF,we); done_o=10; memory bytes read back as 0xBE, 0xEF.
//  - Contention: both ports request in the same cycle from reset.
//    -> port 0 served first, then port 1; with both held, grants alternate 0,1,0,1.
//  - Wrap: port 1 reads 0xFFFF -> second beat at 0x0000; rdata_o = {m[0xFFFF], m[0x0000]}.
//  - Reset in LO during a port 0 write -> next cycle IDLE with all outputs 0, no done_o;
//    the next grant then goes to port 0 on a tie.
//  - STATS (macro defined): 3 port-0 and 2 port-1 accesses -> cnt0_o=3, cnt1_o=2.
//    With CNT_W=2, 5 accesses on port 0 -> cnt0_o holds at 3.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port byte-memory arbiter: FSM state encoding and port indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    // One word access walks every state in order, then returns to IDLE
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HI   = 3'd1,
        LO   = 3'd2,
        CAP  = 3'd3,
        RESP = 3'd4
    } arb_state_t;

    localparam int PORT_FETCH = 0;
    localparam int PORT_DATA  = 1;

    // Index of the set bit in a two-bit one-hot grant (bit1 set -> data port)
    function automatic logic onehot2_idx(input logic [1:0] oh);
        return oh[PORT_DATA];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: one-hot grant from the request pair and the last winner.
// Latency: purely combinational.
// Backpressure: none; a requester that loses simply stays requesting.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_gnt_i,   // index of the port that won last time
    output logic [1:0] gnt_o
);

    // A lone requester always wins; on a tie the port that did not win last time goes
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_gnt_i == 1'b1) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide single-port memory between the fetch and data ports as two big-endian byte beats.
// Latency: request sampled in cycle N, done_o in cycle N+4; at most one access every 5 cycles.
// Backpressure: a losing port holds req_i and is served next; MEM_ARB_STATS_EN adds saturating done counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW    = 16,
    parameter int CNT_W = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [1:0]    req_i,
    input  logic [1:0]    we_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [15:0]   wdata0_i,
    input  logic [15:0]   wdata1_i,
    output logic [1:0]    gnt_o,
    output logic [1:0]    done_o,
    output logic [15:0]   rdata_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [7:0]    mem_wdata_o,
    input  logic [7:0]    mem_rdata_i
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt0_o,
    output logic [CNT_W-1:0] cnt1_o
`endif
);

    arb_state_t    state_q, state_d;
    logic          last_gnt_q, last_gnt_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [7:0]    hi_q, hi_d;

    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    done_q, done_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;

    logic [1:0]    pick;
    logic          pick_idx;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [15:0]   sel_wdata;

    rr_arb2 u_rr_arb2 (
        .req_i      (req_i),
        .last_gnt_i (last_gnt_q),
        .gnt_o      (pick)
    );

    // Steer the winning port's request fields; only consumed at the grant edge
    always_comb begin
        pick_idx  = onehot2_idx(pick);
        sel_we    = pick_idx ? we_i[PORT_DATA] : we_i[PORT_FETCH];
        sel_addr  = pick_idx ? addr1_i  : addr0_i;
        sel_wdata = pick_idx ? wdata1_i : wdata0_i;
    end

    // Next state and next registered outputs; the outputs lead the state by one edge so
    // every memory beat and the done pulse appear in the cycle named by the state
    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        hi_d        = hi_q;
        gnt_d       = gnt_q;
        done_d      = 2'b00;
        rdata_d     = rdata_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    owner_d     = pick_idx;
                    last_gnt_d  = pick_idx;
                    gnt_d       = pick;
                    we_d        = sel_we;
                    addr_d      = sel_addr;
                    wdata_d     = sel_wdata;
                    mem_en_d    = 1'b1;
                    mem_we_d    = sel_we;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata[15:8];
                    state_d     = HI;
                end
            end
            HI: begin
                // Second beat; the address wraps naturally at 2^AW
                mem_addr_d  = addr_q + AW'(1);
                mem_wdata_d = wdata_q[7:0];
                state_d     = LO;
            end
            LO: begin
                hi_d     = mem_rdata_i;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                state_d  = CAP;
            end
            CAP: begin
                if (!we_q) begin
                    rdata_d = {hi_q, mem_rdata_i};
                end
                done_d  = owner_q ? 2'b10 : 2'b01;
                state_d = RESP;
            end
            RESP: begin
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
            default: begin
                gnt_d    = 2'b00;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State, latched request and registered outputs; reset drops any access in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            last_gnt_q  <= 1'b1;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            hi_q        <= '0;
            gnt_q       <= 2'b00;
            done_q      <= 2'b00;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            hi_q        <= hi_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign done_o      = done_q;
    assign rdata_o     = rdata_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

`ifdef MEM_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    // Count completed accesses per port, holding at all-ones instead of wrapping
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (done_q[PORT_FETCH] && (cnt0_q != {CNT_W{1'b1}})) begin
                cnt0_q <= cnt0_q + CNT_W'(1);
            end
            if (done_q[PORT_DATA] && (cnt1_q != {CNT_W{1'b1}})) begin
                cnt1_q <= cnt1_q + CNT_W'(1);
            end
        end
    end

    assign cnt0_o = cnt0_q;
    assign cnt1_o = cnt1_q;
`endif

endmodule
